// File: rtl/slot_pkg.sv
// Shared types and constants for the slot machine controller.
package slot_pkg;

   localparam int SYM_W    = 3;
   localparam int CREDIT_W = 8;
   localparam logic [SYM_W-1:0] JACKPOT_SYMBOL = 3'd7;
   localparam logic [CREDIT_W-1:0] CREDIT_MAX = 8'd255;

   typedef enum logic [2:0] {
      IDLE,
      SPIN,
      STOP1,
      STOP2,
      STOP3,
      EVAL,
      PAYOUT
   } state_t;

   // True when all three packed reel symbols are equal.
   function automatic logic is_triple(input logic [3*SYM_W-1:0] syms);
      return (syms[SYM_W-1:0] == syms[2*SYM_W-1:SYM_W]) &&
             (syms[SYM_W-1:0] == syms[3*SYM_W-1:2*SYM_W]);
   endfunction

endpackage

// File: rtl/slot_game_controller_if.sv
// Player/datapath signal bundle for the slot controller.
interface slot_game_controller_if;
   import slot_pkg::*;

   logic                    coin;
   logic                    spin_req;
   logic [3*SYM_W-1:0]      reel_sym;
   logic [2:0]              reel_run;
   logic [3*SYM_W-1:0]      result;
   logic [CREDIT_W-1:0]     credits;
   logic                    busy;
   logic                    win;
   logic                    jackpot;
   logic                    coin_reject;
   logic                    spin_reject;

   // Controller side.
   modport slave (
      input  coin, spin_req, reel_sym,
      output reel_run, result, credits, busy, win, jackpot, coin_reject, spin_reject
   );

   // Player / datapath side.
   modport master (
      output coin, spin_req, reel_sym,
      input  reel_run, result, credits, busy, win, jackpot, coin_reject, spin_reject
   );

endinterface

// File: rtl/slot_timer.sv
// Loadable 10-bit down-counter; done is high while the count sits at zero.
module slot_timer (
   input  logic       clock,
   input  logic       reset,
   input  logic       load,
   input  logic [9:0] load_val,
   output logic       done
);

   logic [9:0] count;

   // Load takes priority; otherwise count down and park at zero.
   always_ff @(posedge clock) begin
      if (reset)
         count <= '0;
      else if (load)
         count <= load_val;
      else if (count != '0)
         count <= count - 10'd1;
   end

   assign done = (count == '0);

endmodule

// File: rtl/slot_game_controller.sv
// Slot machine controller: credit keeping, reel sequencing and payout.
module slot_game_controller
   import slot_pkg::*;
#(
   parameter int SPIN_CYCLES = 64,
   parameter int STOP_GAP    = 16,
   parameter int PAY_TRIPLE  = 10,
   parameter int PAY_JACKPOT = 50
) (
   input  logic clock,
   input  logic reset,
   slot_game_controller_if.slave bus
);

   state_t              state, next_state;
   logic [CREDIT_W-1:0] credits, credits_next;
   logic [3*SYM_W-1:0]  result;
   logic [2:0]          latch;
   logic                timer_load, timer_done;
   logic [9:0]          timer_val;
   logic                spin_ok;
   logic [8:0]          pay, sum;
   logic                is_jackpot;

   slot_timer u_timer (
      .clock    (clock),
      .reset    (reset),
      .load     (timer_load),
      .load_val (timer_val),
      .done     (timer_done)
   );

   // Result comes from the latched stops, so it is stable through EVAL/PAYOUT.
   assign is_jackpot = (result[SYM_W-1:0] == JACKPOT_SYMBOL);

   // Next-state, reel stop strobes, timer control and payout selection.
   always_comb begin
      next_state = state;
      timer_load = 1'b0;
      timer_val  = '0;
      spin_ok    = 1'b0;
      latch      = 3'b000;
      pay        = '0;
      case (state)
         IDLE: begin
            if (bus.spin_req && credits != '0) begin
               spin_ok    = 1'b1;
               next_state = SPIN;
               timer_load = 1'b1;
               timer_val  = 10'(SPIN_CYCLES - 1);
            end
         end
         SPIN: begin
            if (timer_done) begin
               next_state = STOP1;
               latch[0]   = 1'b1;
               timer_load = 1'b1;
               timer_val  = 10'(STOP_GAP - 1);
            end
         end
         STOP1: begin
            if (timer_done) begin
               next_state = STOP2;
               latch[1]   = 1'b1;
               timer_load = 1'b1;
               timer_val  = 10'(STOP_GAP - 1);
            end
         end
         STOP2: begin
            if (timer_done) begin
               next_state = STOP3;
               latch[2]   = 1'b1;
            end
         end
         STOP3:  next_state = EVAL;
         EVAL:   next_state = is_triple(result) ? PAYOUT : IDLE;
         PAYOUT: begin
            pay        = is_jackpot ? 9'(PAY_JACKPOT) : 9'(PAY_TRIPLE);
            next_state = IDLE;
         end
         default: next_state = IDLE;
      endcase

      // Coin, payout and spin cost combine at 9 bits, then clamp to 8.
      sum          = {1'b0, credits} + 9'(bus.coin) + pay - 9'(spin_ok);
      credits_next = (sum > 9'(CREDIT_MAX)) ? CREDIT_MAX : sum[CREDIT_W-1:0];
   end

   // State, credit balance and per-reel stop latches.
   always_ff @(posedge clock) begin
      if (reset) begin
         state   <= IDLE;
         credits <= '0;
         result  <= '0;
      end else begin
         state   <= next_state;
         credits <= credits_next;
         for (int i = 0; i < 3; i++)
            if (latch[i])
               result[i*SYM_W +: SYM_W] <= bus.reel_sym[i*SYM_W +: SYM_W];
      end
   end

   // Reel enables decode from state; pulses are suppressed while reset is held.
   always_comb begin
      case (state)
         SPIN:    bus.reel_run = 3'b111;
         STOP1:   bus.reel_run = 3'b110;
         STOP2:   bus.reel_run = 3'b100;
         default: bus.reel_run = 3'b000;
      endcase
      bus.busy        = (state != IDLE);
      bus.win         = !reset && (state == PAYOUT);
      bus.jackpot     = !reset && (state == PAYOUT) && is_jackpot;
      // A coin that rides along with an accepted spin nets out, so it is not refused.
      bus.coin_reject = !reset && bus.coin && (credits == CREDIT_MAX) && !spin_ok;
      bus.spin_reject = !reset && bus.spin_req && !spin_ok;
      bus.result      = result;
      bus.credits     = credits;
   end

endmodule

// File: doc/slot_game_controller.md
SLOT_GAME_CONTROLLER -- requirements
Module: slot_game_controller

Interface
REQ-001 SHALL have parameter SPIN_CYCLES, default 64, cycles all reels run before the first stop (range 1..1023).
REQ-002 SHALL have parameter STOP_GAP, default 16, cycles between successive reel stops (range 1..1023).
REQ-003 SHALL have parameter PAY_TRIPLE, default 10, credits paid for three equal symbols other than 7.
REQ-004 SHALL have parameter PAY_JACKPOT, default 50, credits paid for three symbols equal to 7.
REQ-005 SHALL have port clock  input  1  clock; reset reset, synchronous, active-high; clock clock.
REQ-006 SHALL have port reset  input  1  synchronous active-high reset.
REQ-007 SHALL have port coin  input  1  one-cycle pulse inserting one credit.
REQ-008 SHALL have port spin_req  input  1  one-cycle pulse requesting a spin.
REQ-009 SHALL have port reel_sym  input  9  live reel symbols from the datapath: [2:0] reel1, [5:3] reel2, [8:6] reel3.
REQ-010 SHALL have port reel_run  output  3  per-reel run enable to the datapath; bit i high = reel i+1 advancing.
REQ-011 SHALL have port result  output  9  latched stop symbols, same packing as reel_sym.
REQ-012 SHALL have port credits  output  8  current credit balance.
REQ-013 SHALL have port busy  output  1  high in every state except IDLE.
REQ-014 SHALL have port win  output  1  one-cycle pulse when a payout is applied.
REQ-015 SHALL have port jackpot  output  1  one-cycle pulse, coincident with win, for the triple-7 case.
REQ-016 SHALL have port coin_reject  output  1  one-cycle pulse when a coin is dropped at saturation.
REQ-017 SHALL have port spin_reject  output  1  one-cycle pulse when spin_req is refused.

Function
REQ-018 SHALL implement states IDLE, SPIN, STOP1, STOP2, STOP3, EVAL, PAYOUT.
REQ-019 SHALL, in IDLE, accept spin_req only if credits >= 1 (value before this cycle's coin), decrement credits by 1 and enter SPIN next cycle with reel_run = 3'b111.
REQ-020 SHALL pulse spin_req reject for spin_req in IDLE with credits = 0 and for spin_req in any non-IDLE state; the request SHALL be discarded (not queued).
REQ-021 SHALL hold SPIN for exactly SPIN_CYCLES cycles, then, on the transition to STOP1, clear reel_run[0] and latch reel_sym[2:0] into result[2:0].
REQ-022 SHALL hold STOP1 and STOP2 for STOP_GAP cycles each, stopping/latching reel2 on entry to STOP2 and reel3 on entry to STOP3.
REQ-023 SHALL hold STOP3 for one cycle, then EVAL for one cycle, comparing the three latched symbols.
REQ-024 SHALL enter PAYOUT for one cycle when all three are equal: add PAY_JACKPOT (symbol 7) or PAY_TRIPLE (other symbols), pulse win (and jackpot if applicable); otherwise return from EVAL directly to IDLE without a pulse.
REQ-025 SHALL accept coin in every state, adding 1 to credits, saturating at 255; a coin at 255 SHALL pulse coin_reject and leave credits unchanged.
REQ-026 SHALL, for coin and accepted spin_req in the same cycle, leave credits unchanged net (+1 -1).
REQ-027 SHALL, for coin in the PAYOUT cycle, apply coin plus payout together, saturating the sum at 255 (coin_reject only if credits was already 255).
REQ-028 SHALL hold result unchanged from the last stop until the next stop latches; reel_run SHALL be 3'b000 in EVAL, PAYOUT and IDLE.
REQ-029 SHALL compute all credit arithmetic at 9 bits before saturating to 8.

Reset
REQ-030 SHALL, when reset is high at a clock edge, enter IDLE, clear credits, result and reel_run to 0 and deassert busy, win, jackpot, coin_reject, spin_reject; reset SHALL override coin/spin_req in that cycle.
REQ-031 SHALL, on reset mid-spin, abandon the spin without refund; outputs take reset values on the following cycle.

Structure
REQ-032 SHALL take the state enum, symbol width (3), JACKPOT_SYMBOL (7) and credit width (8) from shared package slot_pkg.
REQ-033 SHALL implement the SPIN/STOP_GAP countdown in one sub-module slot_timer (loadable 10-bit down-counter with a done flag).

Verification
REQ-034 SHALL test: reset, spin_req with credits 0 -> spin_reject pulse, state stays IDLE, credits 0.
REQ-035 SHALL test: 3 coins then spin_req -> credits 2, reel_run 111 for 64 cycles, then 110, 100, 000 at 16-cycle gaps, busy high throughout.
REQ-036 SHALL test: reel_sym forced to 7,7,7 at all stops -> win and jackpot pulse once, credits 2 -> 52.
REQ-037 SHALL test: reel_sym 3,3,5 -> no win, credits unchanged after spin, result = {5,3,3}.
REQ-038 SHALL test: credits 250, triple 2 payout with coin in PAYOUT cycle -> credits 255; further coin -> coin_reject, 255 held.
REQ-039 SHALL test: reset asserted during STOP2 -> next cycle IDLE, credits 0, reel_run 000, result 0.
